// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor with parallel load/collect.
// Operands are captured on an accepted start, processed LSB-first one bit per
// clock through a two-state borrow FSM, and the difference plus final borrow
// are presented in parallel together with a one-cycle done pulse.
// Optional feature macro: SERIAL_SUB_OVF_EN builds the two's-complement
// overflow flag; when undefined, ovf is tied to 0 and no overflow logic exists.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  // Bit counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ctrl_t;

  typedef enum logic {
    NB = 1'b0,  // no borrow pending
    BR = 1'b1   // borrow pending into the next bit
  } borrow_t;

  ctrl_t            state_reg,  state_next;
  borrow_t          borrow_reg, borrow_next;
  logic [WIDTH-1:0] ra_reg, ra_next;
  logic [WIDTH-1:0] rb_reg, rb_next;
  logic [WIDTH-1:0] rd_reg, rd_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic             bout_reg, bout_next;

  // Current-bit datapath signals.
  logic bit_a;
  logic bit_b;
  logic bit_d;
  logic last_bit;

  // Bit-serial datapath: difference bit of the current column and end-of-word detect.
  always_comb begin
    bit_a    = ra_reg[0];
    bit_b    = rb_reg[0];
    bit_d    = bit_a ^ bit_b ^ (borrow_reg == BR);
    last_bit = (state_reg == SHIFT) && (count_reg == CW'(WIDTH - 1));
  end

  // State, shift registers and result registers; reset abandons any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      borrow_reg <= NB;
      ra_reg     <= '0;
      rb_reg     <= '0;
      rd_reg     <= '0;
      count_reg  <= '0;
      d_reg      <= '0;
      bout_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      borrow_reg <= borrow_next;
      ra_reg     <= ra_next;
      rb_reg     <= rb_next;
      rd_reg     <= rd_next;
      count_reg  <= count_next;
      d_reg      <= d_next;
      bout_reg   <= bout_next;
    end
  end

  // Next-state logic for the control FSM, the borrow FSM and the datapath.
  always_comb begin
    state_next  = state_reg;
    borrow_next = borrow_reg;
    ra_next     = ra_reg;
    rb_next     = rb_reg;
    rd_next     = rd_reg;
    count_next  = count_reg;
    d_next      = d_reg;
    bout_next   = bout_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          ra_next     = A;
          rb_next     = B;
          borrow_next = NB;
          count_next  = '0;
          state_next  = SHIFT;
        end
      end

      SHIFT: begin
        // Borrow FSM: only a 0-1 column creates a borrow, only a 1-0 column clears it.
        case (borrow_reg)
          NB:      if (!bit_a && bit_b) borrow_next = BR;
          BR:      if (bit_a && !bit_b) borrow_next = NB;
          default: borrow_next = NB;
        endcase

        rd_next    = {bit_d, rd_reg[WIDTH-1:1]};
        ra_next    = {1'b0, ra_reg[WIDTH-1:1]};
        rb_next    = {1'b0, rb_reg[WIDTH-1:1]};
        count_next = count_reg + CW'(1);

        if (last_bit) begin
          d_next     = {bit_d, rd_reg[WIDTH-1:1]};
          bout_next  = (borrow_next == BR);
          state_next = DONE;
        end
      end

      DONE: begin
        // start is deliberately ignored here; it is seen again once in IDLE.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_reg;

  // Two's-complement overflow: operand signs differ and the result sign differs from A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (last_bit) begin
      ovf_reg <= (bit_a != bit_b) && (bit_d != bit_a);
    end
  end

  assign ovf = ovf_reg;
`else
  assign ovf = 1'b0;
`endif

  assign D    = d_reg;
  assign Bout = bout_reg;
  assign busy = (state_reg == SHIFT);
  assign done = (state_reg == DONE);

endmodule
